// File: rtl/conv_pkg.sv
// Shared constants and types for the 5x5 convolution MAC stage.
// Holds the datapath widths, kernel geometry, requantisation shift and the
// configuration FSM state encoding used by the top and its sub-modules.
package conv_pkg;

   localparam int I_F_BW  = 8;    // unsigned pixel width
   localparam int W_BW    = 8;    // signed weight width
   localparam int B_BW    = 16;   // signed bias width
   localparam int KX      = 5;    // kernel width
   localparam int KY      = 5;    // kernel height
   localparam int O_F_BW  = 8;    // unsigned output pixel width
   localparam int SHIFT   = 7;    // requantisation right shift, >= 1

   localparam int KN      = KX * KY;
   // Pixel is zero-extended by one bit so it can enter a signed multiply.
   localparam int PROD_BW = I_F_BW + 1 + W_BW;
   localparam int ACC_BW  = I_F_BW + 1 + W_BW + $clog2(KN) + 1;
   // Counts weight beats 0..KN-1 and the trailing bias beat at KN.
   localparam int CNT_BW  = $clog2(KN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

endpackage

// File: rtl/conv5x5_mac_if.sv
// Bundle of the config stream, window input and output pixel of conv5x5_mac.
// master: the producer/consumer side (drives i_*, observes o_*).
// slave : the conv5x5_mac side (observes i_*, drives o_*).
interface conv5x5_mac_if;
   import conv_pkg::*;

   logic                     i_cfg_start;
   logic                     i_cfg_valid;
   logic [B_BW-1:0]          i_cfg_data;
   logic                     o_cfg_ready;
   logic                     o_cfg_done;
   logic                     i_window_valid;
   logic [KN*I_F_BW-1:0]     i_window;
   logic                     o_out_valid;
   logic [O_F_BW-1:0]        o_out_pixel;

   modport master (
      output i_cfg_start, i_cfg_valid, i_cfg_data, i_window_valid, i_window,
      input  o_cfg_ready, o_cfg_done, o_out_valid, o_out_pixel
   );

   modport slave (
      input  i_cfg_start, i_cfg_valid, i_cfg_data, i_window_valid, i_window,
      output o_cfg_ready, o_cfg_done, o_out_valid, o_out_pixel
   );

endinterface

// File: rtl/requant_relu_sat.sv
// Combinational requantisation of a signed accumulator to an unsigned pixel:
// arithmetic shift right by SHIFT, clamp negatives to 0 (ReLU) and clamp
// values above the output range to all-ones.
// Ports:
//   i_acc   - signed accumulator, rounding term already added
//   o_pixel - unsigned requantised pixel
module requant_relu_sat
   import conv_pkg::*;
(
   input  logic signed [ACC_BW-1:0] i_acc,
   output logic        [O_F_BW-1:0] o_pixel
);

   localparam logic signed [ACC_BW-1:0] MAX_PIX = ACC_BW'((1 << O_F_BW) - 1);

   logic signed [ACC_BW-1:0] shifted;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path can leave it unassigned and infer a latch.
      o_pixel = '0;
      shifted = i_acc >>> SHIFT;
      if (shifted[ACC_BW-1]) begin
         o_pixel = '0;
      end else if (shifted > MAX_PIX) begin
         o_pixel = '1;
      end else begin
         o_pixel = shifted[O_F_BW-1:0];
      end
   end

endmodule

// File: rtl/conv5x5_mac.sv
// 5x5 convolution multiply-accumulate stage fed by the line-buffer window.
// A serial config stream loads 25 signed weights and a bias; afterwards every
// valid window yields one requantised pixel after a 4-stage pipeline
// (products, row sums, total + bias + rounding, shift/ReLU/saturate).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - config stream, window input and pixel output (slave side)
module conv5x5_mac
   import conv_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   conv5x5_mac_if.slave  bus
);

   localparam logic signed [ACC_BW-1:0] ROUND = ACC_BW'(1 << (SHIFT - 1));

   state_t                     state_q,   state_d;
   logic [CNT_BW-1:0]          cfg_cnt_q, cfg_cnt_d;
   logic signed [W_BW-1:0]     weight_q [KN];
   logic signed [W_BW-1:0]     weight_d [KN];
   logic signed [B_BW-1:0]     bias_q,    bias_d;
   logic                       cfg_done;

   logic                       accept;
   logic signed [PROD_BW-1:0]  prod_q [KN];
   logic signed [PROD_BW-1:0]  prod_d [KN];
   logic signed [ACC_BW-1:0]   row_q  [KY];
   logic signed [ACC_BW-1:0]   row_d  [KY];
   logic signed [B_BW-1:0]     bias_p1_q, bias_p1_d;
   logic signed [B_BW-1:0]     bias_p2_q, bias_p2_d;
   logic signed [ACC_BW-1:0]   acc_q,     acc_d;
   logic [O_F_BW-1:0]          pixel_q,   pixel_d;
   logic [3:0]                 vld_q,     vld_d;

   // Config FSM. A start pulse wins over a simultaneous beat in every state.
   always_comb begin
      state_d   = state_q;
      cfg_cnt_d = cfg_cnt_q;
      weight_d  = weight_q;
      bias_d    = bias_q;
      cfg_done  = 1'b0;
      if (bus.i_cfg_start) begin
         state_d   = S_LOAD;
         cfg_cnt_d = '0;
      end else if (state_q == S_LOAD && bus.i_cfg_valid) begin
         if (cfg_cnt_q == CNT_BW'(KN)) begin
            bias_d    = bus.i_cfg_data;
            cfg_done  = 1'b1;
            cfg_cnt_d = '0;
            state_d   = S_RUN;
         end else begin
            weight_d[cfg_cnt_q] = bus.i_cfg_data[W_BW-1:0];
            cfg_cnt_d           = cfg_cnt_q + 1'b1;
         end
      end
   end

   assign accept = bus.i_window_valid && (state_q == S_RUN);

   // Datapath. Weights are consumed at P1 and the bias travels alongside the
   // data, so a reload never alters results already in flight.
   always_comb begin
      for (int k = 0; k < KN; k++) begin
         prod_d[k] = PROD_BW'($signed({1'b0, bus.i_window[k*I_F_BW +: I_F_BW]}))
                   * PROD_BW'(weight_q[k]);
      end
      for (int r = 0; r < KY; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < KX; c++) begin
            row_d[r] = row_d[r] + ACC_BW'(prod_q[r*KX + c]);
         end
      end
      acc_d = ACC_BW'(bias_p2_q) + ROUND;
      for (int r = 0; r < KY; r++) begin
         acc_d = acc_d + row_q[r];
      end
      bias_p1_d = bias_q;
      bias_p2_d = bias_p1_q;
      vld_d     = {vld_q[2:0], accept};
   end

   requant_relu_sat u_requant (
      .i_acc   (acc_q),
      .o_pixel (pixel_d)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // flops sample their inputs from the same pre-edge values.
      if (reset) begin
         state_q   <= S_IDLE;
         cfg_cnt_q <= '0;
         weight_q  <= '{default: '0};
         bias_q    <= '0;
         vld_q     <= '0;
         pixel_q   <= '0;
      end else begin
         state_q   <= state_d;
         cfg_cnt_q <= cfg_cnt_d;
         weight_q  <= weight_d;
         bias_q    <= bias_d;
         vld_q     <= vld_d;
         pixel_q   <= pixel_d;
      end
   end

   // NOTE: the intermediate pipeline registers carry no reset; nothing reads
   // them as meaningful unless the matching vld_q bit is set.
   always_ff @(posedge clk) begin
      prod_q    <= prod_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
      bias_p1_q <= bias_p1_d;
      bias_p2_q <= bias_p2_d;
   end

   assign bus.o_cfg_ready = (state_q == S_LOAD);
   assign bus.o_cfg_done  = cfg_done;
   assign bus.o_out_valid = vld_q[3];
   assign bus.o_out_pixel = pixel_q;

endmodule

// File: tb/tb_conv5x5_mac.sv
// Directed self-checking bench for conv5x5_mac: reset state, latency,
// saturation, ReLU, bias rounding, streaming with mid-stream reload and
// reset during a config load.
module tb_conv5x5_mac;
   import conv_pkg::*;

   typedef logic signed [W_BW-1:0] kern_t [KN];
   typedef logic [KN*I_F_BW-1:0]   win_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   conv5x5_mac_if bus ();

   conv5x5_mac dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   logic [O_F_BW-1:0] out_q [$];

   // Output collector, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.o_out_valid) out_q.push_back(bus.o_out_pixel);
      if (bus.o_cfg_done)  done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic win_t mk_win(input int center, input int rest);
      win_t w;
      for (int k = 0; k < KN; k++) begin
         if (k == KN / 2) w[k*I_F_BW +: I_F_BW] = I_F_BW'(center);
         else             w[k*I_F_BW +: I_F_BW] = I_F_BW'(rest);
      end
      return w;
   endfunction

   function automatic kern_t mk_kern(input int center, input int rest);
      kern_t w;
      for (int k = 0; k < KN; k++) begin
         if (k == KN / 2) w[k] = W_BW'(center);
         else             w[k] = W_BW'(rest);
      end
      return w;
   endfunction

   task automatic load_cfg(input kern_t w, input int bias, input string tag);
      int d0;
      d0 = done_cnt;
      bus.i_cfg_start = 1'b1;
      tick();
      bus.i_cfg_start = 1'b0;
      for (int b = 0; b <= KN; b++) begin
         bus.i_cfg_valid = 1'b1;
         if (b < KN) bus.i_cfg_data = B_BW'(w[b]);
         else        bus.i_cfg_data = B_BW'(bias);
         tick();
      end
      bus.i_cfg_valid = 1'b0;
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_ready"}, bus.o_cfg_ready, 1'b0);
   endtask

   task automatic run_one(input win_t win, input int exp, input string tag);
      out_q.delete();
      bus.i_window       = win;
      bus.i_window_valid = 1'b1;
      tick();
      bus.i_window_valid = 1'b0;
      repeat (8) tick();
      check({tag, "_count"}, out_q.size(), 1);
      if (out_q.size() > 0) check(tag, out_q[0], exp);
   endtask

   initial begin
      int d0;
      int exp_q [$];

      reset              = 1'b1;
      bus.i_cfg_start    = 1'b0;
      bus.i_cfg_valid    = 1'b0;
      bus.i_cfg_data     = '0;
      bus.i_window_valid = 1'b0;
      bus.i_window       = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_valid", bus.o_out_valid, 1'b0);
      check("rst_pixel", bus.o_out_pixel, 0);
      check("rst_ready", bus.o_cfg_ready, 1'b0);
      check("rst_done",  bus.o_cfg_done,  1'b0);
      reset = 1'b0;
      tick();

      // Windows in S_IDLE are dropped.
      out_q.delete();
      bus.i_window       = mk_win(200, 0);
      bus.i_window_valid = 1'b1;
      repeat (5) tick();
      bus.i_window_valid = 1'b0;
      repeat (8) tick();
      check("idle_drop", out_q.size(), 0);

      // Center weight 64: 200*64+64 = 12864 >> 7 = 100, valid on 4th edge.
      load_cfg(mk_kern(64, 0), 0, "cfg_c64");
      out_q.delete();
      bus.i_window       = mk_win(200, 0);
      bus.i_window_valid = 1'b1;
      tick();
      bus.i_window_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check($sformatf("lat_vld%0d", j), bus.o_out_valid, (j == 3));
         if (j == 3) check("lat_pixel", bus.o_out_pixel, 100);
         tick();
      end
      @(negedge clk);
      check("lat_vld_off", bus.o_out_valid, 1'b0);
      repeat (4) tick();
      // 255*64+64 = 16384 >> 7 = 128
      run_one(mk_win(255, 0), 128, "c64_p255");

      // Saturation: 25*255*127 far above 255.
      load_cfg(mk_kern(127, 127), 0, "cfg_all127");
      run_one(mk_win(255, 255), 255, "sat");

      // Exactly at the top of range, and just below it.
      load_cfg(mk_kern(64, 0), 16256, "cfg_b16256");
      run_one(mk_win(255, 0), 255, "edge255");   // 32640 >> 7 = 255
      run_one(mk_win(254, 0), 254, "edge254");   // 32576 >> 7 = 254

      // ReLU from a negative weight.
      load_cfg(mk_kern(-64, 0), 0, "cfg_cm64");
      run_one(mk_win(200, 0), 0, "relu");

      // Bias only: (1000+64) >> 7 = 8; negative bias must sign-extend.
      load_cfg(mk_kern(0, 0), 1000, "cfg_b1000");
      run_one(mk_win(77, 33), 8, "bias_pos");
      load_cfg(mk_kern(0, 0), -1000, "cfg_bm1000");
      run_one(mk_win(77, 33), 0, "bias_neg");

      // Stream: center 64, bias 128 -> (128*i+192) >> 7 = i+1 for center 2*i.
      // The window present with the start pulse is still accepted; later ones
      // are dropped until the load completes, then center 32 applies.
      load_cfg(mk_kern(64, 0), 128, "cfg_stream");
      out_q.delete();
      for (int i = 0; i < 10; i++) begin
         bus.i_window       = mk_win(2 * i, 0);
         bus.i_window_valid = 1'b1;
         tick();
      end
      bus.i_window = mk_win(20, 0);
      load_cfg(mk_kern(32, 0), 0, "cfg_reload");
      bus.i_window_valid = 1'b0;
      repeat (8) tick();
      bus.i_window       = mk_win(200, 0);   // 200*32+64 = 6464 >> 7 = 50
      bus.i_window_valid = 1'b1;
      tick();
      bus.i_window_valid = 1'b0;
      repeat (8) tick();
      for (int i = 1; i <= 11; i++) exp_q.push_back(i);
      exp_q.push_back(50);
      check("stream_count", out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         check($sformatf("stream%0d", i), out_q[i], exp_q[i]);
      end

      // Reset during the 12th config beat; windows keep arriving throughout.
      out_q.delete();
      d0 = done_cnt;
      bus.i_cfg_start = 1'b1;
      tick();
      bus.i_cfg_start    = 1'b0;
      bus.i_window       = mk_win(200, 0);
      bus.i_window_valid = 1'b1;
      for (int b = 0; b < 11; b++) begin
         bus.i_cfg_valid = 1'b1;
         bus.i_cfg_data  = 16'd100;
         tick();
      end
      reset = 1'b1;
      tick();
      bus.i_cfg_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check($sformatf("mid_rst_vld%0d", j), bus.o_out_valid, 1'b0);
         tick();
      end
      check("mid_rst_ready", bus.o_cfg_ready, 1'b0);
      reset = 1'b0;
      repeat (6) tick();
      bus.i_window_valid = 1'b0;
      repeat (6) tick();
      check("mid_rst_nodone", done_cnt - d0, 0);
      check("mid_rst_drop", out_q.size(), 0);
      load_cfg(mk_kern(64, 0), 0, "cfg_after_rst");
      run_one(mk_win(200, 0), 100, "after_rst");
      run_one(mk_win(200, 200), 100, "after_rst_clear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
